cond_eval_stage: RTL and testbench

//  Registered condition-evaluation stage sitting between decode and execute.

---
 rtl/cpu_pkg.sv | 59 +++++
 rtl/cond_eval.sv | 18 +
 rtl/cond_eval_stage.sv | 106 ++++++++++
 tb/tb_cond_eval_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition-code encodings, NZCV bit positions and
// the condition-pass evaluation used by the execute-side condition stage and
// the branch unit.
package cpu_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Returns 1 when the condition field passes against the given {N,Z,C,V}.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, p;
    n = nzcv[FLAG_N];
    z = nzcv[FLAG_Z];
    c = nzcv[FLAG_C];
    v = nzcv[FLAG_V];
    p = 1'b0;
    case (cond_e'(cond))
      COND_EQ: p = z;
      COND_NE: p = !z;
      COND_CS: p = c;
      COND_CC: p = !c;
      COND_MI: p = n;
      COND_PL: p = !n;
      COND_VS: p = v;
      COND_VC: p = !v;
      COND_HI: p = c && !z;
      COND_LS: p = !c || z;
      COND_GE: p = (n == v);
      COND_LT: p = (n != v);
      COND_GT: p = !z && (n == v);
      COND_LE: p = z || (n != v);
      COND_AL: p = 1'b1;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational condition evaluator.
// Ports:
//   cond  in  4  condition field
//   nzcv  in  4  flags {N,Z,C,V}
//   pass  out 1  condition holds
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  always_comb begin
    pass = cond_pass(cond, nzcv);
  end

endmodule

// File: rtl/cond_eval_stage.sv
// Registered condition-evaluation stage between decode and execute.
// Holds architectural NZCV, evaluates inst[INST_W-1 -: 4] against them,
// stalls conditional instructions while flag setters are in flight, and
// bypasses flags returning from writeback into the same-cycle evaluation.
// Ports:
//   clk, rst_n                  clock / async active-low reset
//   in_valid, in_ready          upstream handshake
//   in_inst, in_sets_flags      instruction and its S bit
//   flag_wr_valid, flag_wr_nzcv NZCV returned by writeback (oldest setter)
//   flush                       squash output and in-flight setters
//   out_valid, out_ready        downstream handshake
//   out_inst, out_exec          registered instruction, condition passed
//   out_sets_flags              setter whose condition passed
//   nzcv, pending_cnt, err      flags, in-flight setter count, sticky error
module cond_eval_stage
  import cpu_pkg::*;
#(
  parameter  int unsigned INST_W      = 32,
  parameter  int unsigned MAX_PENDING = 4,
  localparam int unsigned CNT_W       = $clog2(MAX_PENDING + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic              in_sets_flags,
  input  logic              flag_wr_valid,
  input  logic [3:0]        flag_wr_nzcv,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic              out_exec,
  output logic              out_sets_flags,
  output logic [3:0]        nzcv,
  output logic [CNT_W-1:0]  pending_cnt,
  output logic              err
);

  logic [3:0]       cond;
  logic [3:0]       eff_nzcv;
  logic             dec;
  logic [CNT_W-1:0] eff_pend;
  logic             uncond;
  logic             stall;
  logic             pass;
  logic             accept;
  logic             inc;

  assign cond = in_inst[INST_W-1 -: 4];

  // Writeback flags are visible to this cycle's evaluation and pending count.
  always_comb begin
    eff_nzcv = flag_wr_valid ? flag_wr_nzcv : nzcv;
    dec      = flag_wr_valid && (pending_cnt != '0);
    eff_pend = pending_cnt - CNT_W'(dec);
    uncond   = (cond == COND_AL) || (cond == COND_NV);
    stall    = in_valid && ((!uncond && (eff_pend != '0)) ||
                            (in_sets_flags && (eff_pend == CNT_W'(MAX_PENDING))));
    in_ready = !flush && !stall && (!out_valid || out_ready);
    accept   = in_valid && in_ready;
    inc      = accept && in_sets_flags && pass;
  end

  cond_eval u_cond_eval (
    .cond (cond),
    .nzcv (eff_nzcv),
    .pass (pass)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_inst       <= '0;
      out_exec       <= 1'b0;
      out_sets_flags <= 1'b0;
      nzcv           <= '0;
      pending_cnt    <= '0;
      err            <= 1'b0;
    end else begin
      if (flag_wr_valid) begin
        nzcv <= flag_wr_nzcv;
        if (pending_cnt == '0) begin
          err <= 1'b1;
        end
      end

      if (flush) begin
        out_valid   <= 1'b0;
        pending_cnt <= '0;
      end else begin
        pending_cnt <= eff_pend + CNT_W'(inc);
        if (accept) begin
          out_valid      <= 1'b1;
          out_inst       <= in_inst;
          out_exec       <= pass;
          out_sets_flags <= in_sets_flags && pass;
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cond_eval_stage.sv
module tb_cond_eval_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic        in_sets_flags;
  logic        flag_wr_valid;
  logic [3:0]  flag_wr_nzcv;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_exec;
  logic        out_sets_flags;
  logic [3:0]  nzcv;
  logic [2:0]  pending_cnt;
  logic        err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cond_eval_stage #(.INST_W(32), .MAX_PENDING(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_inst        (in_inst),
    .in_sets_flags  (in_sets_flags),
    .flag_wr_valid  (flag_wr_valid),
    .flag_wr_nzcv   (flag_wr_nzcv),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_exec       (out_exec),
    .out_sets_flags (out_sets_flags),
    .nzcv           (nzcv),
    .pending_cnt    (pending_cnt),
    .err            (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_sets_flags = 0; in_inst = '0;
    flag_wr_valid = 0; flag_wr_nzcv = '0; flush = 0;
  endtask

  task automatic test_reset();
    idle();
    out_ready = 1;
    rst_n = 0;
    #12;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
    total++; if (out_inst !== 32'h0) begin bad++; $display("FAIL reset_out_inst got=%0h exp=0", out_inst); end
    total++; if (out_exec !== 1'b0) begin bad++; $display("FAIL reset_out_exec got=%0h exp=0", out_exec); end
    total++; if (out_sets_flags !== 1'b0) begin bad++; $display("FAIL reset_out_sets got=%0h exp=0", out_sets_flags); end
    total++; if (nzcv !== 4'h0) begin bad++; $display("FAIL reset_nzcv got=%0h exp=0", nzcv); end
    total++; if (pending_cnt !== 3'd0) begin bad++; $display("FAIL reset_pending got=%0d exp=0", pending_cnt); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0h exp=0", err); end
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  // nzcv=0000: EQ fails, NE passes, AL passes, NV never passes.
  task automatic test_back_to_back();
    logic [3:0] conds [4];
    logic       exps  [4];
    conds = '{4'h0, 4'h1, 4'hE, 4'hF};
    exps  = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_sets_flags = 0; in_inst = {conds[i], 28'h0000100 + 28'(i)};
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready[%0d] got=%0h exp=1", i, in_ready); end
      tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_out_valid[%0d] got=%0h exp=1", i, out_valid); end
      total++; if (out_exec !== exps[i]) begin bad++; $display("FAIL b2b_out_exec[%0d] got=%0h exp=%0h", i, out_exec, exps[i]); end
      total++; if (out_inst !== {conds[i], 28'h0000100 + 28'(i)}) begin bad++; $display("FAIL b2b_out_inst[%0d] got=%0h", i, out_inst); end
    end
    idle();
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%0h exp=0", out_valid); end
  endtask

  task automatic test_stall_bypass();
    in_valid = 1; in_sets_flags = 1; in_inst = 32'hE0000201;   // ADDS, AL
    tick();
    total++; if (out_sets_flags !== 1'b1) begin bad++; $display("FAIL sb_adds_sets got=%0h exp=1", out_sets_flags); end
    total++; if (pending_cnt !== 3'd1) begin bad++; $display("FAIL sb_pend1 got=%0d exp=1", pending_cnt); end
    in_sets_flags = 0; in_inst = 32'h0A000202;                  // BEQ
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL sb_stall0 got=%0h exp=0", in_ready); end
    tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL sb_stall1 got=%0h exp=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sb_bubble got=%0h exp=0", out_valid); end
    flag_wr_valid = 1; flag_wr_nzcv = 4'b0100;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL sb_bypass_ready got=%0h exp=1", in_ready); end
    tick();
    total++; if (out_valid !== 1'b1 || out_inst !== 32'h0A000202) begin bad++; $display("FAIL sb_beq_out got=%0h/%0h exp=1/0a000202", out_valid, out_inst); end
    total++; if (out_exec !== 1'b1) begin bad++; $display("FAIL sb_beq_exec got=%0h exp=1", out_exec); end
    total++; if (pending_cnt !== 3'd0) begin bad++; $display("FAIL sb_pend0 got=%0d exp=0", pending_cnt); end
    total++; if (nzcv !== 4'b0100) begin bad++; $display("FAIL sb_nzcv got=%0h exp=4", nzcv); end
    idle();
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    in_valid = 1; in_inst = 32'hE0000301;
    tick();
    in_inst = 32'hE0000302;
    for (int i = 0; i < 3; i++) begin
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d] got=%0h exp=0", i, in_ready); end
      total++; if (out_valid !== 1'b1 || out_inst !== 32'hE0000301) begin bad++; $display("FAIL bp_hold[%0d] got=%0h/%0h exp=1/e0000301", i, out_valid, out_inst); end
      tick();
    end
    out_ready = 1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%0h exp=1", in_ready); end
    tick();
    total++; if (out_inst !== 32'hE0000302) begin bad++; $display("FAIL bp_next got=%0h exp=e0000302", out_inst); end
    idle();
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%0h exp=0", out_valid); end
  endtask

  task automatic test_max_pending();
    in_valid = 1; in_sets_flags = 1;
    for (int i = 0; i < 4; i++) begin
      in_inst = 32'hE0000400 + 32'(i);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mp_ready[%0d] got=%0h exp=1", i, in_ready); end
      tick();
    end
    total++; if (pending_cnt !== 3'd4) begin bad++; $display("FAIL mp_full got=%0d exp=4", pending_cnt); end
    in_inst = 32'hE0000405;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mp_stall got=%0h exp=0", in_ready); end
    flag_wr_valid = 1; flag_wr_nzcv = 4'b0000;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mp_bypass_ready got=%0h exp=1", in_ready); end
    tick();
    total++; if (pending_cnt !== 3'd4) begin bad++; $display("FAIL mp_incdec got=%0d exp=4", pending_cnt); end
    total++; if (out_inst !== 32'hE0000405) begin bad++; $display("FAIL mp_fifth got=%0h exp=e0000405", out_inst); end
    // Non-setter AL alongside one more writeback leaves three in flight.
    in_sets_flags = 0; in_inst = 32'hE0000406;
    tick();
    total++; if (pending_cnt !== 3'd3) begin bad++; $display("FAIL mp_pend3 got=%0d exp=3", pending_cnt); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mp_valid got=%0h exp=1", out_valid); end
    idle();
  endtask

  task automatic test_flush();
    flush = 1; flag_wr_valid = 1; flag_wr_nzcv = 4'b1001;
    in_valid = 1; in_inst = 32'hE0000501;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fl_ready got=%0h exp=0", in_ready); end
    tick();
    total++; if (pending_cnt !== 3'd0) begin bad++; $display("FAIL fl_pend got=%0d exp=0", pending_cnt); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_valid got=%0h exp=0", out_valid); end
    total++; if (nzcv !== 4'b1001) begin bad++; $display("FAIL fl_nzcv got=%0h exp=9", nzcv); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL fl_err got=%0h exp=0", err); end
    idle();
    // N=1,V=1,Z=0: GT holds (N==V), LT does not.
    in_valid = 1; in_inst = 32'hC0000502;
    tick();
    total++; if (out_exec !== 1'b1) begin bad++; $display("FAIL fl_gt got=%0h exp=1", out_exec); end
    in_inst = 32'hB0000503;
    tick();
    total++; if (out_exec !== 1'b0) begin bad++; $display("FAIL fl_lt got=%0h exp=0", out_exec); end
    idle();
    tick();
  endtask

  task automatic test_err_async_reset();
    flag_wr_valid = 1; flag_wr_nzcv = 4'b0010;
    tick();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL er_set got=%0h exp=1", err); end
    total++; if (pending_cnt !== 3'd0) begin bad++; $display("FAIL er_pend got=%0d exp=0", pending_cnt); end
    total++; if (nzcv !== 4'b0010) begin bad++; $display("FAIL er_nzcv got=%0h exp=2", nzcv); end
    idle();
    tick(); tick();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL er_sticky got=%0h exp=1", err); end
    out_ready = 0;
    in_valid = 1; in_sets_flags = 1; in_inst = 32'hE0000601;
    tick();
    in_sets_flags = 0; in_inst = 32'h0A000602;
    tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL er_stalled got=%0h exp=0", in_ready); end
    #2;
    rst_n = 0;
    #1;
    total++; if (out_valid !== 1'b0 || out_inst !== 32'h0) begin bad++; $display("FAIL ar_out got=%0h/%0h exp=0/0", out_valid, out_inst); end
    total++; if (out_exec !== 1'b0 || out_sets_flags !== 1'b0) begin bad++; $display("FAIL ar_exec got=%0h/%0h exp=0/0", out_exec, out_sets_flags); end
    total++; if (nzcv !== 4'h0 || pending_cnt !== 3'd0) begin bad++; $display("FAIL ar_state got=%0h/%0d exp=0/0", nzcv, pending_cnt); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL ar_err got=%0h exp=0", err); end
    idle();
    out_ready = 1;
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall_bypass();
    test_backpressure();
    test_max_pending();
    test_flush();
    test_err_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
